// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic RST_ENABLE = 1'b1;
    localparam int FETCH_BUF_DEPTH = 4;
    localparam logic [INST_ADDR_W-1:0] PC_STEP = 32'd4;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        inst_addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return addr & ~inst_addr_t'(3);
    endfunction

    // Wraps from 32'hFFFFFFFC to 0 by plain modular addition.
    function automatic inst_addr_t next_pc(input inst_addr_t addr);
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - circular fetch buffer with separate alloc, fill and pop pointers
module fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         alloc_en,
    input  inst_addr_t   alloc_pc,
    input  logic         fill_en,
    input  inst_t        fill_inst,
    input  logic         pop_en,
    output logic         head_valid,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t      ent_q [DEPTH];
    logic [DEPTH-1:0]  done_q;
    logic [AW-1:0]     alloc_ptr;
    logic [AW-1:0]     fill_ptr;
    logic [AW-1:0]     pop_ptr;
    logic [CW-1:0]     cnt;

    // fill_ptr always points at the oldest allocated entry still waiting for its word.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            pop_ptr   <= '0;
            cnt       <= '0;
            done_q    <= '0;
        end else begin
            if (alloc_en) begin
                done_q[alloc_ptr] <= 1'b0;
                alloc_ptr         <= alloc_ptr + 1'b1;
            end
            if (fill_en) begin
                done_q[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + 1'b1;
            end
            if (pop_en) begin
                pop_ptr <= pop_ptr + 1'b1;
            end
            cnt <= cnt + CW'(alloc_en) - CW'(pop_en);
        end
    end

    // Payload needs no reset; validity comes only from cnt and done_q.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            ent_q[alloc_ptr].pc <= alloc_pc;
        end
        if (fill_en) begin
            ent_q[fill_ptr].inst <= fill_inst;
        end
    end

    assign head_valid = (cnt != '0) && done_q[pop_ptr];
    assign head       = ent_q[pop_ptr];
    assign count      = cnt;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: pc sequencing, credit and wrong-path drop
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic                   if_valid_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    inst_addr_t    pc;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_sum;
    logic          issue;
    logic          resp_drop;
    logic          resp_fill;
    logic          resp_stray;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  head;

    // Entries already allocated plus wrong-path words still owed bound the request window.
    assign credit_sum = {1'b0, buf_count} + {1'b0, drop_cnt};
    assign imem_req_o = (rst != RST_ENABLE) && (credit_sum < CREDIT_MAX);
    assign imem_addr_o = pc;
    assign issue = imem_req_o && imem_gnt_i;

    assign resp_drop  = imem_rvalid_i && (drop_cnt != '0);
    assign resp_fill  = imem_rvalid_i && (drop_cnt == '0) && (live_cnt != '0);
    assign resp_stray = imem_rvalid_i && (drop_cnt == '0) && (live_cnt == '0);

    assign pop = head_valid && !stall_i && !branch_flag_i;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc       <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else if (branch_flag_i) begin
            // Everything still owed by memory, including this cycle's grant, turns into drops.
            pc       <= word_align(branch_target_i);
            live_cnt <= '0;
            drop_cnt <= drop_cnt + live_cnt + CW'(issue) - CW'(resp_drop || resp_fill);
        end else begin
            if (issue) begin
                pc <= next_pc(pc);
            end
            live_cnt <= live_cnt + CW'(issue) - CW'(resp_fill);
            drop_cnt <= drop_cnt - CW'(resp_drop);
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (branch_flag_i),
        .alloc_en   (issue && !branch_flag_i),
        .alloc_pc   (pc),
        .fill_en    (resp_fill && !branch_flag_i),
        .fill_inst  (imem_rdata_i),
        .pop_en     (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (buf_count)
    );

    assign if_valid_o = head_valid;
    assign if_pc_o    = head_valid ? head.pc : ZERO_WORD;
    assign if_inst_o  = head_valid ? head.inst : ZERO_WORD;

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst == RST_ENABLE) !resp_stray);

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with an in-order memory model
module tb_if_fetch;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_rand = 1'b0;
    logic [31:0] key = 32'h0;
    logic [31:0] mq_addr [$];
    int          mq_due [$];
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check outputs against the model.
    task automatic pre(input logic s, input logic b, input logic [31:0] t);
        stall_i = s;
        branch_flag_i = b;
        branch_target_i = t;
        imem_gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = mq_addr[0] ^ key;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i = $urandom;
        end
        #1;
        if (if_valid_o) begin
            chk("pc", if_pc_o, exp_pc);
            chk("inst", if_inst_o, exp_pc ^ key);
        end else begin
            chk("idle_pc", if_pc_o, 32'h0);
            chk("idle_inst", if_inst_o, 32'h0);
        end
        if (imem_req_o) chk("issue_addr", imem_addr_o, exp_issue);
        chk1("inflight_bound", mq_addr.size() <= DEPTH, 1'b1);
    endtask

    // Advance through the rising edge and update memory model and expected program order.
    task automatic post();
        logic        iss = imem_req_o && imem_gnt_i;
        logic [31:0] iaddr = imem_addr_o;
        logic        rv = imem_rvalid_i;
        logic        popped = if_valid_o && !stall_i;
        @(posedge clk);
        if (rv) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (iss) begin
            mq_addr.push_back(iaddr);
            mq_due.push_back(cyc + lat);
        end
        if (branch_flag_i) begin
            exp_pc = branch_target_i & ~32'h3;
            exp_issue = branch_target_i & ~32'h3;
        end else begin
            if (iss) exp_issue = exp_issue + 32'd4;
            if (popped) exp_pc = exp_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        mq_addr.delete();
        mq_due.delete();
        repeat (n) @(posedge clk);
        #1;
        chk1("rst_req", imem_req_o, 1'b0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk1("rst_valid", if_valid_o, 1'b0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        exp_issue = RESET_PC;
        cyc = 0;
    endtask

    task automatic wait_valid(input int bound, input string name, input logic [31:0] exp_p);
        int n = 0;
        pre(1'b0, 1'b0, 32'h0);
        while (!if_valid_o && n < bound) begin
            post();
            pre(1'b0, 1'b0, 32'h0);
            n++;
        end
        chk1({name, "_valid"}, if_valid_o, 1'b1);
        chk(name, if_pc_o, exp_p);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t x;
        x.stall = s;
        x.exp_req = r;
        x.exp_addr = a;
        x.exp_valid = v;
        x.exp_pc = p;
        return x;
    endfunction

    initial begin
        logic [31:0] issued [$];
        logic [31:0] shown [$];
        logic [31:0] wrap_exp [3];
        int pops;

        // Reset release, steady streaming, then a 6-cycle stall that fills the buffer.
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h04, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h08, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h0C, 1, 32'h04));
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h08));
        vecs.push_back(mk(0, 1, 32'h14, 1, 32'h0C));
        vecs.push_back(mk(1, 1, 32'h18, 1, 32'h10));
        vecs.push_back(mk(1, 1, 32'h1C, 1, 32'h10));
        vecs.push_back(mk(1, 0, 32'h20, 1, 32'h10));
        vecs.push_back(mk(1, 0, 32'h20, 1, 32'h10));
        vecs.push_back(mk(1, 0, 32'h20, 1, 32'h10));
        vecs.push_back(mk(1, 0, 32'h20, 1, 32'h10));
        vecs.push_back(mk(0, 0, 32'h20, 1, 32'h10));
        vecs.push_back(mk(0, 1, 32'h20, 1, 32'h14));
        vecs.push_back(mk(0, 1, 32'h24, 1, 32'h18));
        vecs.push_back(mk(0, 1, 32'h28, 1, 32'h1C));
        vecs.push_back(mk(0, 1, 32'h2C, 1, 32'h20));
        vecs.push_back(mk(0, 1, 32'h30, 1, 32'h24));

        do_reset(2);
        lat = 1;
        gnt_rand = 1'b0;
        key = 32'h0;
        foreach (vecs[i]) begin
            pre(vecs[i].stall, 1'b0, 32'h0);
            chk1("tbl_req", imem_req_o, vecs[i].exp_req);
            if (vecs[i].exp_req) chk("tbl_addr", imem_addr_o, vecs[i].exp_addr);
            chk1("tbl_valid", if_valid_o, vecs[i].exp_valid);
            chk("tbl_pc", if_pc_o, vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0);
            chk("tbl_inst", if_inst_o, vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0);
            post();
        end

        // Branch coinciding with a grant of 0x10 and the response for 0x0C.
        do_reset(1);
        repeat (4) begin
            pre(1'b0, 1'b0, 32'h0);
            post();
        end
        pre(1'b0, 1'b1, 32'h103);
        chk1("br_req", imem_req_o, 1'b1);
        chk("br_grant_addr", imem_addr_o, 32'h10);
        post();
        wait_valid(10, "br_target", 32'h100);
        post();
        pre(1'b0, 1'b0, 32'h0);
        chk("br_next", if_pc_o, 32'h104);
        post();

        // Three-cycle memory with three requests owed at the branch.
        do_reset(1);
        lat = 3;
        repeat (3) begin
            pre(1'b0, 1'b0, 32'h0);
            post();
        end
        pre(1'b0, 1'b1, 32'h200);
        post();
        wait_valid(20, "lat3_target", 32'h200);
        post();
        pre(1'b0, 1'b0, 32'h0);
        chk("lat3_next", if_pc_o, 32'h204);
        post();

        // Reset mid-stream with responses still pending; memory is reset alongside.
        do_reset(1);
        lat = 2;
        repeat (6) begin
            pre(1'b0, 1'b0, 32'h0);
            post();
        end
        do_reset(1);
        pre(1'b0, 1'b0, 32'h0);
        chk1("restart_req", imem_req_o, 1'b1);
        chk("restart_addr", imem_addr_o, RESET_PC);
        post();
        wait_valid(10, "restart_pc", RESET_PC);
        post();

        // Address wrap at the top of the address space.
        lat = 1;
        pre(1'b0, 1'b1, 32'hFFFF_FFF8);
        post();
        for (int k = 0; k < 6; k++) begin
            pre(1'b0, 1'b0, 32'h0);
            if (imem_req_o && imem_gnt_i) issued.push_back(imem_addr_o);
            if (if_valid_o) shown.push_back(if_pc_o);
            post();
        end
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            chk("wrap_issue", (k < issued.size()) ? issued[k] : 32'hDEAD_BEEF, wrap_exp[k]);
            chk("wrap_shown", (k < shown.size()) ? shown[k] : 32'hDEAD_BEEF, wrap_exp[k]);
        end

        // Randomised traffic: stalls, branches, grant gaps and several memory latencies.
        for (int blk = 0; blk < 6; blk++) begin
            lat = 1 + (blk % 3);
            gnt_rand = 1'b1;
            key = $urandom;
            do_reset(1);
            pops = 0;
            for (int n = 0; n < 500; n++) begin
                logic        s = ($urandom_range(0, 3) == 0);
                logic        b = ($urandom_range(0, 19) == 0);
                logic [31:0] t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
                pre(s, b, t);
                if (if_valid_o && !s && !b) pops++;
                post();
            end
            chk1("progress", pops >= 50, 1'b1);
        end
        gnt_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage. Drives the PC sequence, issues requests to instruction memory and buffers returned words in program order.
- Presents one {pc, inst} pair per cycle to decode, which consumes it through the pc_i/inst_i inputs.
- Handles decode-side stall, branch redirect, and discard of in-flight wrong-path responses.

Parameters:
DEPTH, 4, entries in the fetch buffer; power of two, minimum 2; also the cap on outstanding plus buffered requests.
RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1).
stall_i  in  1  decode cannot accept this cycle; hold the head entry.
branch_flag_i  in  1  redirect fetch this cycle.
branch_target_i  in  32  redirect address; bits [1:0] forced to 0.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  32  fetch address, word aligned.
imem_gnt_i  in  1  request accepted this cycle (req & gnt = issue).
imem_rvalid_i  in  1  response valid; responses return in issue order.
imem_rdata_i  in  32  response instruction word.
if_valid_o  out  1  if_pc_o/if_inst_o hold a valid instruction.
if_pc_o  out  32  PC of the presented instruction (feeds decode pc_i).
if_inst_o  out  32  instruction word (feeds decode inst_i).

Behaviour:
- Reset: pc = RESET_PC; buffer empty; outstanding = 0; drop_cnt = 0.
  - Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, if_valid_o = 0, if_pc_o = 0, if_inst_o = 0.
  - Reset asserted mid-operation discards everything, including in-flight responses; no drop accounting survives reset.
- Buffer entry: {pc, inst, done}.
  - On issue, the entry is allocated at the tail with pc = imem_addr_o and done = 0.
  - On a response, the oldest not-done entry is filled (inst = rdata, done = 1).
- Issue rule: imem_req_o = !rst && (entries + drop_cnt < DEPTH). imem_addr_o = pc. On issue, pc += 4; wrap from 32'hFFFFFFFC to 0 silently.
- Output: if_valid_o = head entry valid && done. if_pc_o/if_inst_o = head fields when valid, otherwise 0, which decode treats as a NOP.
- Pop: the head pops when if_valid_o && !stall_i.
- Latency: rvalid in cycle N gives if_valid_o in cycle N+1. There is no same-cycle bypass.
- Stall: the head is held stable. Issue continues until the credit rule blocks. Responses keep filling entries.
- Branch (branch_flag_i = 1 in cycle N); branch has priority over stall and pop:
  - Every buffer entry is flushed at the edge.
  - drop_cnt_next = drop_cnt + (issued-not-returned requests, including a grant in cycle N) − (1 if rvalid in cycle N).
  - The request in cycle N (if any) uses the old pc.
  - pc_next = {branch_target_i[31:2], 2'b00}. Cycle N+1 requests the target.
- Drop: while drop_cnt > 0, each rvalid decrements drop_cnt and is discarded without filling an entry. New-path requests may issue while drops are pending, subject to the credit rule.
- Simultaneous events in one cycle: issue, response, pop and branch may all coincide. Entry count = count + issue − pop; branch overrides to zero. A branch coinciding with a pending drop adds to drop_cnt.
- rvalid with no outstanding request and drop_cnt = 0 is a protocol error: ignore it and flag it with a simulation assertion.
- Back-to-back: with gnt held high and a 1-cycle memory, sustained throughput is 1 instruction per cycle when stall_i = 0.

Decomposition:
- defines.v holds the shared constants: `InstAddrBus, `InstBus, `ZeroWord, `RstEnable, and the new `FetchBufDepth.
- Sub-module fetch_buf holds the circular buffer with separate alloc, fill and pop pointers plus flush.
- if_fetch keeps the pc, outstanding counter, drop_cnt and credit logic.

Test Plan:
- Reset release, gnt = 1, 1-cycle memory returning addr as data, stall_i = 0 → issues 0, 4, 8, …; if_valid_o rises 2 cycles after reset release with pc = 0, inst = 0, then one instruction per cycle.
- Hold stall_i = 1 for 6 cycles → the head stays at the same pc; imem_req_o drops once 4 entries are allocated; after release, pcs appear consecutively with no gap or duplicate.
- branch_flag_i in the same cycle as a grant of 0x10 and an rvalid for 0x0C, target 0x103 → both wrong-path words discarded; next if_pc_o = 0x100, followed by 0x104.
- Memory latency 3 cycles with a branch while 3 requests are outstanding → drop_cnt = 3; exactly 3 responses discarded; the first presented pc equals the target.
- Assert rst for 1 cycle mid-stream with 2 responses pending, memory also reset → all outputs 0; fetch restarts at RESET_PC.
- pc = 32'hFFFFFFF8, no stalls → issues 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
